// File: rtl/mem_arbiter.sv
// Word-access arbiter sharing one byte-wide memory between fetch and data ports (4 big-endian beats).
// Optional: define ARB_RR_EN for round-robin tie-breaking; otherwise the data port wins ties.
module mem_arbiter #(
  parameter int MEM_BYTES = 20,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, TAIL, RESP} state_t;

  localparam logic [31:0] MEM_LIMIT = MEM_BYTES;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        beat_q, beat_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       rbuf_q, rbuf_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
`ifdef ARB_RR_EN
  logic              rr_last_q, rr_last_d;
`endif

  logic        grant_data;
  logic [31:0] req_addr;
  logic [31:0] req_last;
  logic        req_bad;
  logic [1:0]  next_beat;
  logic        unused_addr_lsb;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    word_byte = word[31:24];
      2'd1:    word_byte = word[23:16];
      2'd2:    word_byte = word[15:8];
      default: word_byte = word[7:0];
    endcase
  endfunction

  // rr_last_q high means the data port took the previous grant
`ifdef ARB_RR_EN
  assign grant_data = d_req && !(if_req && rr_last_q);
`else
  assign grant_data = d_req;
`endif
  assign req_addr        = grant_data ? d_addr : if_addr;
  assign req_last        = {req_addr[31:2], 2'b11};
  assign req_bad         = req_last >= MEM_LIMIT;
  assign next_beat       = beat_q + 2'd1;
  assign unused_addr_lsb = ^req_addr[1:0];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    base_d      = base_q;
    beat_d      = beat_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = 1'b0;
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
`ifdef ARB_RR_EN
    rr_last_d   = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          owner_d = grant_data;
          we_d    = grant_data && d_we;
          base_d  = {req_last[ADDR_W-1:2], 2'b00};
          wdata_d = d_wdata;
          beat_d  = 2'd0;
`ifdef ARB_RR_EN
          rr_last_d = grant_data;
`endif
          if (req_bad) begin
            state_d = RESP;
            err_d   = 1'b1;
            if (grant_data) begin
              d_done_d  = 1'b1;
              d_rdata_d = '0;
            end else begin
              if_done_d  = 1'b1;
              if_rdata_d = '0;
            end
          end else begin
            state_d     = XFER;
            mem_addr_d  = base_d;
            mem_we_d    = we_d;
            mem_wdata_d = we_d ? d_wdata[31:24] : 8'h00;
          end
        end
      end
      XFER: begin
        // memory read data lags the address by one cycle, so beat N lands in byte N-1
        case (beat_q)
          2'd1:    rbuf_d[23:16] = mem_rdata;
          2'd2:    rbuf_d[15:8]  = mem_rdata;
          2'd3:    rbuf_d[7:0]   = mem_rdata;
          default: ;
        endcase
        if (beat_q == 2'd3) begin
          state_d = TAIL;
        end else begin
          beat_d      = next_beat;
          mem_addr_d  = base_q + ADDR_W'(next_beat);
          mem_we_d    = we_q;
          mem_wdata_d = we_q ? word_byte(wdata_q, next_beat) : 8'h00;
        end
      end
      TAIL: begin
        state_d = RESP;
        if (owner_q) begin
          d_done_d  = 1'b1;
          d_rdata_d = we_q ? 32'h0 : {rbuf_q, mem_rdata};
        end else begin
          if_done_d  = 1'b1;
          if_rdata_d = {rbuf_q, mem_rdata};
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      base_q      <= '0;
      beat_q      <= 2'd0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
`ifdef ARB_RR_EN
      rr_last_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      base_q      <= base_d;
      beat_q      <= beat_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef ARB_RR_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  // a write beat coinciding with reset is dropped so an aborted word never lands a further byte
  assign mem_we    = mem_we_q & ~reset;
  assign mem_wdata = mem_wdata_q;

endmodule
